// File: rtl/risc8_pkg.sv
// risc8_pkg: shared widths, sizes and the write-back entry type for the risc8 core.
package risc8_pkg;
    localparam int DATA_W = 8;
    localparam int ADDR_W = 3;
    localparam int NREGS  = 8;
    localparam int DEPTH  = 4;
    localparam int CNT_W  = $clog2(DEPTH + 1);
    localparam logic [ADDR_W-1:0] REG_ZERO = 3'd0;
    typedef struct packed {
        logic [ADDR_W-1:0] wa;
        logic [DATA_W-1:0] wd;
    } wb_entry_t;
endpackage

// File: rtl/regfile_wb_port_if.sv
// regfile_wb_port_if: producer handshakes, regfile write port and decode busy query.
//   slave  = write-back port side, master = EX/MEM/decode/regfile side.
interface regfile_wb_port_if;
    import risc8_pkg::*;
    logic              alu_valid, alu_ready;
    logic [ADDR_W-1:0] alu_wa;
    logic [DATA_W-1:0] alu_wd;
    logic              mem_valid, mem_ready;
    logic [ADDR_W-1:0] mem_wa;
    logic [DATA_W-1:0] mem_wd;
    logic              rf_we;
    logic [ADDR_W-1:0] rf_wa;
    logic [DATA_W-1:0] rf_wd;
    logic [ADDR_W-1:0] chk_ra1, chk_ra2;
    logic              busy1, busy2, q_empty;
    logic [CNT_W-1:0]  q_count;
    modport slave (
        input  alu_valid, alu_wa, alu_wd, mem_valid, mem_wa, mem_wd, chk_ra1, chk_ra2,
        output alu_ready, mem_ready, rf_we, rf_wa, rf_wd, busy1, busy2, q_empty, q_count
    );
    modport master (
        output alu_valid, alu_wa, alu_wd, mem_valid, mem_wa, mem_wd, chk_ra1, chk_ra2,
        input  alu_ready, mem_ready, rf_we, rf_wa, rf_wd, busy1, busy2, q_empty, q_count
    );
endinterface

// File: rtl/wb_fifo.sv
// wb_fifo: N-entry circular buffer, two pushes (port0 ahead of port1) and one pop per cycle.
//   Ports: clk, reset (async high), push0/d0, push1/d1, pop, head, count, empty.
//   Caller guarantees no overflow and no pop when empty.
module wb_fifo
    import risc8_pkg::*;
#(
    parameter int N = DEPTH
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push0,
    input  wb_entry_t                  d0,
    input  logic                       push1,
    input  wb_entry_t                  d1,
    input  logic                       pop,
    output wb_entry_t                  head,
    output logic [$clog2(N+1)-1:0]     count,
    output logic                       empty
);
    localparam int PW = $clog2(N);
    localparam int CW = $clog2(N + 1);
    wb_entry_t     mem [N];
    logic [PW-1:0] wp, rp;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
            for (int i = 0; i < N; i++) mem[i] <= '0;
        end else begin
            if (push0) mem[wp] <= d0;
            if (push1) mem[wp + PW'(push0)] <= d1;
            wp    <= wp + PW'(push0) + PW'(push1);
            rp    <= rp + PW'(pop);
            count <= count + CW'(push0) + CW'(push1) - CW'(pop);
        end
    end
    assign head  = mem[rp];
    assign empty = count == '0;
endmodule

// File: rtl/regfile_wb_port.sv
// regfile_wb_port: queues ALU/load results in order and issues one regfile write per cycle.
//   Ports: clk, reset (async high), bus (regfile_wb_port_if.slave).
module regfile_wb_port
    import risc8_pkg::*;
(
    input logic               clk,
    input logic               reset,
    regfile_wb_port_if.slave  bus
);
    wb_entry_t        head;
    logic             empty, pop, alu_enq, mem_enq;
    logic [CNT_W-1:0] count, free;
    logic [CNT_W-1:0] pend [NREGS];
    // Readiness depends only on pre-pop occupancy; ALU owns the last free slot.
    assign free          = CNT_W'(DEPTH) - count;
    assign bus.alu_ready = free != '0;
    assign bus.mem_ready = free >= CNT_W'(2) || (free != '0 && !bus.alu_valid);
    // r0 writes are handshaken but dropped.
    assign alu_enq = bus.alu_valid && bus.alu_ready && bus.alu_wa != REG_ZERO;
    assign mem_enq = bus.mem_valid && bus.mem_ready && bus.mem_wa != REG_ZERO;
    assign pop     = !empty;
    wb_fifo #(.N(DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push0 (alu_enq),
        .d0    ('{wa: bus.alu_wa, wd: bus.alu_wd}),
        .push1 (mem_enq),
        .d1    ('{wa: bus.mem_wa, wd: bus.mem_wd}),
        .pop   (pop),
        .head  (head),
        .count (count),
        .empty (empty)
    );
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) pend[i] <= '0;
        end else begin
            for (int i = 0; i < NREGS; i++)
                pend[i] <= pend[i]
                         + CNT_W'(alu_enq && bus.alu_wa == ADDR_W'(i))
                         + CNT_W'(mem_enq && bus.mem_wa == ADDR_W'(i))
                         - CNT_W'(pop && head.wa == ADDR_W'(i));
        end
    end
    assign bus.rf_we   = pop;
    assign bus.rf_wa   = empty ? '0 : head.wa;
    assign bus.rf_wd   = empty ? '0 : head.wd;
    assign bus.q_empty = empty;
    assign bus.q_count = count;
    assign bus.busy1   = bus.chk_ra1 != REG_ZERO && pend[bus.chk_ra1] != '0;
    assign bus.busy2   = bus.chk_ra2 != REG_ZERO && pend[bus.chk_ra2] != '0;
endmodule

// File: tb/tb_regfile_wb_port.sv
// tb_regfile_wb_port: directed and randomized checks of regfile_wb_port against a queue model.
module tb_regfile_wb_port;
    typedef struct {
        logic [2:0] wa;
        logic [7:0] wd;
    } ent_t;

    logic clk = 0;
    logic reset = 1;
    int   tests = 0;
    int   fails = 0;
    ent_t q[$];

    regfile_wb_port_if bus();
    regfile_wb_port dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h @%0t", name, got, exp, $time);
        end
    endtask

    function automatic bit m_busy(input logic [2:0] r);
        if (r == 0) return 0;
        foreach (q[i]) if (q[i].wa == r) return 1;
        return 0;
    endfunction

    function automatic int m_free();
        return 4 - q.size();
    endfunction

    // Model of one clock edge: readiness from pre-edge occupancy, pop head, push ALU then mem.
    task automatic model_edge();
        int  f  = m_free();
        bit  ar = f >= 1;
        bit  mr = f >= 2 || (f >= 1 && !bus.alu_valid);
        if (q.size() != 0) void'(q.pop_front());
        if (bus.alu_valid && ar && bus.alu_wa != 0) q.push_back('{bus.alu_wa, bus.alu_wd});
        if (bus.mem_valid && mr && bus.mem_wa != 0) q.push_back('{bus.mem_wa, bus.mem_wd});
    endtask

    task automatic set_in(input bit av, input logic [2:0] awa, input logic [7:0] awd,
                          input bit mv, input logic [2:0] mwa, input logic [7:0] mwd);
        bus.alu_valid = av; bus.alu_wa = awa; bus.alu_wd = awd;
        bus.mem_valid = mv; bus.mem_wa = mwa; bus.mem_wd = mwd;
    endtask

    task automatic cyc(input bit av, input logic [2:0] awa, input logic [7:0] awd,
                       input bit mv, input logic [2:0] mwa, input logic [7:0] mwd);
        set_in(av, awa, awd, mv, mwa, mwd);
        @(posedge clk);
        if (!reset) model_edge();
        #1;
        set_in(0, 0, 0, 0, 0, 0);
        #1;
    endtask

    // Compare process: every negedge, all outputs against the model.
    always @(negedge clk) begin
        chk("rf_we",     bus.rf_we, q.size() != 0);
        chk("rf_wa",     bus.rf_wa, q.size() != 0 ? q[0].wa : 3'd0);
        chk("rf_wd",     bus.rf_wd, q.size() != 0 ? q[0].wd : 8'd0);
        chk("q_empty",   bus.q_empty, q.size() == 0);
        chk("q_count",   bus.q_count, q.size());
        chk("alu_ready", bus.alu_ready, m_free() >= 1);
        chk("mem_ready", bus.mem_ready, m_free() >= 2 || (m_free() >= 1 && !bus.alu_valid));
        chk("busy1",     bus.busy1, m_busy(bus.chk_ra1));
        chk("busy2",     bus.busy2, m_busy(bus.chk_ra2));
    end

    initial begin
        set_in(0, 0, 0, 0, 0, 0);
        bus.chk_ra1 = 3; bus.chk_ra2 = 5;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_we", bus.rf_we, 0);
        chk("rst_empty", bus.q_empty, 1);
        chk("rst_count", bus.q_count, 0);
        reset = 0;
        // Single ALU write to r3.
        cyc(1, 3, 8'h5A, 0, 0, 0);
        chk("t1_we", bus.rf_we, 1); chk("t1_wa", bus.rf_wa, 3); chk("t1_wd", bus.rf_wd, 8'h5A);
        chk("t1_busy", bus.busy1, 1);
        cyc(0, 0, 0, 0, 0, 0);
        chk("t1_busy_clr", bus.busy1, 0); chk("t1_we_clr", bus.rf_we, 0);
        // r0 write is consumed but dropped.
        set_in(1, 0, 8'hFF, 0, 0, 0); #1;
        chk("t2_ready", bus.alu_ready, 1);
        cyc(1, 0, 8'hFF, 0, 0, 0);
        chk("t2_count", bus.q_count, 0); chk("t2_we", bus.rf_we, 0);
        // ALU and mem same cycle: ALU first.
        cyc(1, 1, 8'h11, 1, 2, 8'h22);
        chk("t3_wa1", bus.rf_wa, 1); chk("t3_wd1", bus.rf_wd, 8'h11); chk("t3_cnt", bus.q_count, 2);
        cyc(0, 0, 0, 0, 0, 0);
        chk("t3_wa2", bus.rf_wa, 2); chk("t3_wd2", bus.rf_wd, 8'h22);
        cyc(0, 0, 0, 0, 0, 0);
        chk("t3_empty", bus.q_empty, 1);
        // Saturating producers: occupancy tops out with ALU priority.
        cyc(1, 1, 8'hA1, 1, 2, 8'hB1);
        cyc(1, 3, 8'hA2, 1, 4, 8'hB2);
        chk("t4_cnt3", bus.q_count, 3);
        set_in(1, 5, 8'hA3, 1, 6, 8'hB3); #1;
        chk("t4_mrdy", bus.mem_ready, 0); chk("t4_ardy", bus.alu_ready, 1);
        cyc(1, 5, 8'hA3, 1, 6, 8'hB3);
        chk("t4_cnt", bus.q_count, 3); chk("t4_head", bus.rf_wd, 8'hA2);
        repeat (4) cyc(0, 0, 0, 0, 0, 0);
        // Same register twice: in-order, busy until second pop.
        cyc(1, 5, 8'h01, 0, 0, 0);
        chk("t5_wd1", bus.rf_wd, 8'h01); chk("t5_busy", bus.busy2, 1);
        cyc(1, 5, 8'h02, 0, 0, 0);
        chk("t5_wd2", bus.rf_wd, 8'h02); chk("t5_busy2", bus.busy2, 1);
        cyc(0, 0, 0, 0, 0, 0);
        chk("t5_busy_clr", bus.busy2, 0);
        // Mid-cycle reset with three entries queued.
        cyc(1, 1, 8'h31, 1, 2, 8'h32);
        cyc(1, 3, 8'h33, 1, 4, 8'h34);
        chk("t6_cnt", bus.q_count, 3);
        #1; reset = 1; q.delete(); #1;
        chk("t6_we", bus.rf_we, 0); chk("t6_cnt0", bus.q_count, 0); chk("t6_busy", bus.busy1, 0);
        @(posedge clk); #2; reset = 0;
        cyc(1, 4, 8'h44, 0, 0, 0);
        chk("t6_we2", bus.rf_we, 1); chk("t6_wa2", bus.rf_wa, 4); chk("t6_wd2", bus.rf_wd, 8'h44);
        // Randomized traffic checked by the compare process.
        for (int n = 0; n < 400; n++) begin
            bus.chk_ra1 = 3'($urandom_range(0, 7));
            bus.chk_ra2 = 3'($urandom_range(0, 7));
            cyc($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), 8'($urandom),
                $urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), 8'($urandom));
        end
        repeat (6) cyc(0, 0, 0, 0, 0, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
